// File: rtl/lib_operation.sv
// Shared operation types for the multi-cycle CPU: instruction stages,
// sequencer control states and the stage-advance helper.
package lib_operation;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    DECODE   = 2'd1,
    EXECUTE  = 2'd2,
    MEMSTORE = 2'd3
  } STAGE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } CTRL_STATE;

  // Instruction stage order; MEMSTORE wraps back to FETCH.
  function automatic STAGE next_stage(input STAGE s);
    case (s)
      FETCH:    return DECODE;
      DECODE:   return EXECUTE;
      EXECUTE:  return MEMSTORE;
      MEMSTORE: return FETCH;
      default:  return FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits for its acknowledge and
// flags expiry in the cycle the wait would reach MEM_TIMEOUT without an ack.
// A request only ever drops when its stage completes or the sequencer leaves
// ACTIVE, so clearing on !req also covers every stage change.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
  localparam bit TIMER_EN = (MEM_TIMEOUT > 0);

  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_cnt_nxt_s;

  // Next wait count: clear when idle or acked, saturate at the limit.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (!req || ack) begin
      wait_cnt_nxt_s = '0;
    end else if (wait_cnt_r == LIMIT_V) begin
      wait_cnt_nxt_s = wait_cnt_r;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // An ack in the final cycle wins over expiry.
  assign expired = TIMER_EN && req && !ack && (wait_cnt_r == LIMIT_V);

endmodule

// File: rtl/stage_sequencer.sv
// Control FSM for the multi-cycle CPU: steps FETCH->DECODE->EXECUTE->MEMSTORE,
// handshakes with memory in FETCH and storing MEMSTORE, emits stage-complete
// strobes, counts retired instructions and handles halt, run/stop and timeout.
module stage_sequencer
  import lib_operation::*;
#(
  parameter int RETIRE_W    = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                halt,
  input  logic                store_needs_mem,
  input  logic                mem_ack,
  output logic [1:0]          stage,
  output logic                mem_req,
  output logic                mem_we,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                exec_en,
  output logic                store_en,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                timeout_err
);

  CTRL_STATE ctrl_r;
  CTRL_STATE ctrl_nxt_s;
  STAGE      stage_r;
  STAGE      stage_nxt_s;

  logic                halt_lat_r;
  logic                store_lat_r;
  logic [RETIRE_W-1:0] retired_r;

  logic req_s;
  logic we_s;
  logic done_s;
  logic expired_s;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .ack     (mem_ack),
    .expired (expired_s)
  );

  // Control state and stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r  <= IDLE;
      stage_r <= FETCH;
    end else begin
      ctrl_r  <= ctrl_nxt_s;
      stage_r <= stage_nxt_s;
    end
  end

  // Next control state and stage; an instruction always runs to MEMSTORE completion.
  always_comb begin
    ctrl_nxt_s  = ctrl_r;
    stage_nxt_s = stage_r;
    case (ctrl_r)
      IDLE: begin
        if (run) begin
          ctrl_nxt_s = ACTIVE;
        end else begin
          ctrl_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (expired_s) begin
          ctrl_nxt_s = ERROR;
        end else if (done_s) begin
          stage_nxt_s = next_stage(stage_r);
          if (stage_r != MEMSTORE) begin
            ctrl_nxt_s = ACTIVE;
          end else if (halt_lat_r) begin
            ctrl_nxt_s = HALTED;
          end else if (!run) begin
            ctrl_nxt_s = IDLE;
          end else begin
            ctrl_nxt_s = ACTIVE;
          end
        end else begin
          ctrl_nxt_s = ACTIVE;
        end
      end
      HALTED:  ctrl_nxt_s = HALTED;
      ERROR:   ctrl_nxt_s = ERROR;
      default: ctrl_nxt_s = ERROR;
    endcase
  end

  // Memory handshake, stage completion and one-cycle completion strobes.
  always_comb begin
    req_s  = 1'b0;
    we_s   = 1'b0;
    done_s = 1'b0;
    if (ctrl_r == ACTIVE) begin
      case (stage_r)
        FETCH: begin
          req_s  = 1'b1;
          done_s = mem_ack;
        end
        DECODE:  done_s = 1'b1;
        EXECUTE: done_s = 1'b1;
        MEMSTORE: begin
          if (store_lat_r) begin
            req_s  = 1'b1;
            we_s   = 1'b1;
            done_s = mem_ack;
          end else begin
            done_s = 1'b1;
          end
        end
        default: done_s = 1'b0;
      endcase
    end else begin
      done_s = 1'b0;
    end
    fetch_en  = done_s && (stage_r == FETCH);
    decode_en = done_s && (stage_r == DECODE);
    exec_en   = done_s && (stage_r == EXECUTE);
    store_en  = done_s && (stage_r == MEMSTORE);
  end

  // Decoder flag latches and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_lat_r  <= 1'b0;
      store_lat_r <= 1'b0;
      retired_r   <= '0;
    end else begin
      if (decode_en) begin
        halt_lat_r  <= halt;
        store_lat_r <= store_needs_mem;
      end
      if (store_en) begin
        retired_r <= retired_r + RETIRE_W'(1);
      end
    end
  end

  assign stage       = stage_r;
  assign mem_req     = req_s;
  assign mem_we      = we_s;
  assign retired     = retired_r;
  assign halted      = (ctrl_r == HALTED);
  assign timeout_err = (ctrl_r == ERROR);

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: an instruction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_stage_sequencer;

  localparam int RW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic halt = 1'b0;
  logic store_needs_mem = 1'b0;
  logic mem_ack = 1'b0;

  logic [1:0]    stage;
  logic          mem_req, mem_we, fetch_en, decode_en, exec_en, store_en;
  logic [RW-1:0] retired;
  logic          halted, timeout_err;

  always #5 clk = ~clk;

  stage_sequencer #(.RETIRE_W(RW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt),
    .store_needs_mem(store_needs_mem), .mem_ack(mem_ack),
    .stage(stage), .mem_req(mem_req), .mem_we(mem_we),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .store_en(store_en), .retired(retired), .halted(halted),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Literal expectations posted by the scenario process, checked by the compare process.
  string       lit_name [256];
  logic [31:0] lit_act  [256];
  logic [31:0] lit_exp  [256];
  int          lit_wr = 0;
  int          lit_rd = 0;

  task automatic expect_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_name[lit_wr] = nm;
    lit_act[lit_wr]  = act;
    lit_exp[lit_wr]  = exp;
    lit_wr++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: mode 0=idle 1=running 2=halted 3=error; stage 0..3.
  int            m_mode = 0, m_stage = 0, m_wait = 0;
  logic          m_halt = 1'b0, m_store = 1'b0;
  logic [RW-1:0] m_ret = '0;

  // Compare process: drains literal expectations, checks outputs against the model, advances the model.
  always @(negedge clk) begin : compare
    int            c_mode, c_stage, c_wait;
    logic          c_halt, c_store, e_req, e_done;
    logic [RW-1:0] c_ret;
    while (lit_rd < lit_wr) begin
      chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
    if (rst) begin
      c_mode = 0; c_stage = 0; c_wait = 0; c_halt = 1'b0; c_store = 1'b0; c_ret = '0;
    end else begin
      c_mode = m_mode; c_stage = m_stage; c_wait = m_wait;
      c_halt = m_halt; c_store = m_store; c_ret = m_ret;
    end
    e_req  = (c_mode == 1) && ((c_stage == 0) || ((c_stage == 3) && c_store));
    e_done = (c_mode == 1) && (e_req ? mem_ack : 1'b1);
    chk("stage", 32'(stage), 32'(c_stage));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) chk("mem_we", 32'(mem_we), 32'(c_stage == 3));
    chk("fetch_en", 32'(fetch_en), 32'(e_done && c_stage == 0));
    chk("decode_en", 32'(decode_en), 32'(e_done && c_stage == 1));
    chk("exec_en", 32'(exec_en), 32'(e_done && c_stage == 2));
    chk("store_en", 32'(store_en), 32'(e_done && c_stage == 3));
    chk("retired", 32'(retired), 32'(c_ret));
    chk("halted", 32'(halted), 32'(c_mode == 2));
    chk("timeout_err", 32'(timeout_err), 32'(c_mode == 3));
    if (!rst) begin
      if (c_mode == 1) begin
        if (e_done) begin
          if (c_stage == 1) begin
            c_halt  = halt;
            c_store = store_needs_mem;
          end
          c_wait = 0;
          if (c_stage == 3) begin
            c_ret  = c_ret + 1;
            c_mode = c_halt ? 2 : (run ? 1 : 0);
          end
          c_stage = (c_stage + 1) % 4;
        end else if (e_req) begin
          c_wait = c_wait + 1;
          if (TO > 0 && c_wait >= TO) c_mode = 3;
        end
      end else if (c_mode == 0 && run) begin
        c_mode = 1;
      end
    end
    m_mode <= c_mode; m_stage <= c_stage; m_wait <= c_wait;
    m_halt <= c_halt; m_store <= c_store; m_ret <= c_ret;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Directed scenarios.
  initial begin : scenario
    int rq, fe, we, sb, idx_f, idx_s;
    repeat (2) tick();
    rst = 1'b0;
    settle();
    expect_lit("rst_stage", 32'(stage), 32'd0);
    expect_lit("rst_retired", 32'(retired), 32'd0);
    expect_lit("rst_mem_req", 32'(mem_req), 32'd0);

    // Zero-wait memory: F,D,E,M every 4 cycles, three retire in 12.
    run = 1'b1; mem_ack = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      settle();
      expect_lit("t1_stage_seq", 32'(stage), 32'(i % 4));
      tick();
    end
    settle();
    expect_lit("t1_retired3", 32'(retired), 32'd3);
    run = 1'b0;
    repeat (4) tick();
    settle();
    expect_lit("t1_retired4", 32'(retired), 32'd4);

    // FETCH ack delayed 3 cycles: 4 request cycles, 7-cycle instruction.
    mem_ack = 1'b0; run = 1'b1;
    tick();
    rq = 0; fe = 0; idx_f = -1; idx_s = -1;
    for (int i = 0; i < 7; i++) begin
      mem_ack = (i >= 3);
      if (i == 4) run = 1'b0;
      settle();
      if (mem_req) rq++;
      if (fetch_en) begin fe++; idx_f = i; end
      if (store_en) idx_s = i;
      tick();
    end
    expect_lit("t2_req_cycles", 32'(rq), 32'd4);
    expect_lit("t2_fetch_pulses", 32'(fe), 32'd1);
    expect_lit("t2_fetch_cycle", 32'(idx_f), 32'd3);
    expect_lit("t2_store_cycle", 32'(idx_s), 32'd6);

    // Storing MEMSTORE, ack after 2 wait cycles.
    run = 1'b1; mem_ack = 1'b1; store_needs_mem = 1'b1;
    tick();
    we = 0; idx_s = -1;
    for (int i = 0; i < 7; i++) begin
      mem_ack = (i <= 2) || (i >= 5);
      if (i == 1) run = 1'b0;
      settle();
      if (mem_req && mem_we) we++;
      if (store_en) idx_s = i;
      tick();
    end
    store_needs_mem = 1'b0;
    expect_lit("t3_write_cycles", 32'(we), 32'd3);
    expect_lit("t3_store_cycle", 32'(idx_s), 32'd5);
    expect_lit("t3_retired", 32'(retired), 32'd6);

    // Halt instruction retires, then quiescent with run still high.
    run = 1'b1; mem_ack = 1'b1; halt = 1'b1;
    tick();
    repeat (4) tick();
    halt = 1'b0;
    settle();
    expect_lit("t4_halted", 32'(halted), 32'd1);
    expect_lit("t4_retired", 32'(retired), 32'd7);
    rq = 0; sb = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (mem_req) rq++;
      if (fetch_en || decode_en || exec_en || store_en) sb++;
      tick();
    end
    expect_lit("t4_req_quiet", 32'(rq), 32'd0);
    expect_lit("t4_strobes_quiet", 32'(sb), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    expect_lit("t4_rst_halted", 32'(halted), 32'd0);
    expect_lit("t4_rst_retired", 32'(retired), 32'd0);

    // Ack never arrives: error after 15 request cycles.
    mem_ack = 1'b0;
    tick();
    rq = 0; sb = 0;
    for (int i = 0; i < 25; i++) begin
      settle();
      if (mem_req) rq++;
      if (fetch_en || decode_en || exec_en || store_en) sb++;
      tick();
    end
    expect_lit("t5_req_cycles", 32'(rq), 32'd15);
    expect_lit("t5_strobes", 32'(sb), 32'd0);
    expect_lit("t5_timeout_err", 32'(timeout_err), 32'd1);
    expect_lit("t5_stage_held", 32'(stage), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    expect_lit("t5_rst_timeout", 32'(timeout_err), 32'd0);

    // Ack arriving in the would-be expiry cycle wins.
    tick();
    idx_f = -1;
    for (int i = 0; i < 18; i++) begin
      mem_ack = (i >= 14);
      if (i == 15) run = 1'b0;
      settle();
      if (fetch_en) idx_f = i;
      tick();
    end
    expect_lit("t5b_fetch_cycle", 32'(idx_f), 32'd14);
    expect_lit("t5b_no_timeout", 32'(timeout_err), 32'd0);
    expect_lit("t5b_retired", 32'(retired), 32'd1);

    // Run dropped in EXECUTE, then re-raised in IDLE.
    run = 1'b1; mem_ack = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i == 2) run = 1'b0;
      if (i == 4) run = 1'b1;
      if (i == 5) run = 1'b0;
      settle();
      if (i == 3) expect_lit("t6_store_en", 32'(store_en), 32'd1);
      if (i == 4) begin
        expect_lit("t6_idle_req", 32'(mem_req), 32'd0);
        expect_lit("t6_idle_stage", 32'(stage), 32'd0);
      end
      if (i == 5) expect_lit("t6_resume_fetch", 32'(fetch_en), 32'd1);
      tick();
    end
    expect_lit("t6_retired", 32'(retired), 32'd3);

    // Asynchronous reset during a MEMSTORE wait.
    run = 1'b1; mem_ack = 1'b1; store_needs_mem = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i < 3);
      if (i == 1) run = 1'b0;
      settle();
      tick();
    end
    settle();
    expect_lit("t7_waiting_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    expect_lit("t7_req", 32'(mem_req), 32'd0);
    expect_lit("t7_we", 32'(mem_we), 32'd0);
    expect_lit("t7_store_en", 32'(store_en), 32'd0);
    expect_lit("t7_retired", 32'(retired), 32'd0);
    expect_lit("t7_stage", 32'(stage), 32'd0);
    tick();
    rst = 1'b0; store_needs_mem = 1'b0;
    repeat (2) tick();
    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
